// File: rtl/id_exe_stage_hs.sv
// ID->EXE pipeline stage: valid/ready handshake, main register plus one skid entry, flush, link-dst override.
// Latency: 1 cycle from accepted input to out_valid; full throughput of one entry per cycle when streaming.
// Backpressure: in_ready is registered and drops only when both entries are held (SKID); flush reopens it.
module id_exe_stage_hs #(
   parameter int CTRL_W    = 12,
   parameter int PAYLOAD_W = 101,
   parameter int ADDR_W    = 5,
   parameter int LINK_REG  = 31,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CTRL_W-1:0]    in_ctrl,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [ADDR_W-1:0]    in_dst,
   input  logic                 in_link,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [ADDR_W-1:0]    out_dst,
   output logic                 out_link,
   output logic [CNT_W-1:0]     bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Main register M drives the outputs; skid register S absorbs the one
   // entry accepted while EXE stalls (in_ready is one cycle late).
   logic [CTRL_W-1:0]    m_ctrl;
   logic [PAYLOAD_W-1:0] m_payload;
   logic [ADDR_W-1:0]    m_dst;
   logic                 m_link;
   logic [CTRL_W-1:0]    s_ctrl;
   logic [PAYLOAD_W-1:0] s_payload;
   logic [ADDR_W-1:0]    s_dst;
   logic                 s_link;

   logic                 push;
   logic                 pop;
   logic [ADDR_W-1:0]    cap_dst;
   logic                 load_m_in;
   logic                 load_m_skid;
   logic                 load_s;
   logic                 out_valid_q;

   assign push    = in_valid & in_ready;
   assign pop     = out_valid_q & out_ready;
   assign cap_dst = in_link ? ADDR_W'(LINK_REG) : in_dst;

   // Next state and register-load strobes; flush wins over any push.
   always_comb begin
      state_nxt   = state;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  state_nxt = ST_FULL;
                  load_m_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (push && pop) begin
                  load_m_in = 1'b1;
               end else if (push) begin
                  state_nxt = ST_SKID;
                  load_s    = 1'b1;
               end else if (pop) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (pop) begin
                  state_nxt   = ST_FULL;
                  load_m_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // State register with registered handshake outputs derived from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready    <= 1'b1;
      end else begin
         state       <= state_nxt;
         out_valid_q <= (state_nxt != ST_EMPTY);
         in_ready    <= (state_nxt != ST_SKID);
      end
   end

   // Entry storage; a flushed entry needs no clearing since out_valid gates ctrl/link.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ctrl    <= '0;
         m_payload <= '0;
         m_dst     <= '0;
         m_link    <= 1'b0;
         s_ctrl    <= '0;
         s_payload <= '0;
         s_dst     <= '0;
         s_link    <= 1'b0;
      end else begin
         if (load_m_in) begin
            m_ctrl    <= in_ctrl;
            m_payload <= in_payload;
            m_dst     <= cap_dst;
            m_link    <= in_link;
         end else if (load_m_skid) begin
            m_ctrl    <= s_ctrl;
            m_payload <= s_payload;
            m_dst     <= s_dst;
            m_link    <= s_link;
         end
         if (load_s) begin
            s_ctrl    <= in_ctrl;
            s_payload <= in_payload;
            s_dst     <= cap_dst;
            s_link    <= in_link;
         end
      end
   end

   // Saturating count of cycles where EXE was ready but got a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bubble_cnt <= '0;
      end else if (out_ready && !out_valid_q && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

   // Bubble zero-forcing keeps ctrl/link inert so EXE never writes on an empty slot.
   assign out_valid   = out_valid_q;
   assign out_ctrl    = out_valid_q ? m_ctrl : '0;
   assign out_link    = out_valid_q & m_link;
   assign out_payload = m_payload;
   assign out_dst     = m_dst;

endmodule

// File: tb/tb_id_exe_stage_hs.sv
// Testbench for id_exe_stage_hs: directed scenarios plus random traffic against a queue model.
// A second instance with LINK_REG=30 and CNT_W=4 shares the stimulus.
module tb_id_exe_stage_hs;
   localparam int CW = 12;
   localparam int PW = 101;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_link = 1'b0;
   logic [CW-1:0] in_ctrl = '0;
   logic [PW-1:0] in_payload = '0;
   logic [AW-1:0] in_dst = '0;

   logic          in_ready, out_valid, out_link;
   logic [CW-1:0] out_ctrl;
   logic [PW-1:0] out_payload;
   logic [AW-1:0] out_dst;
   logic [15:0]   bubble_cnt;

   logic          in_ready2, out_valid2, out_link2;
   logic [CW-1:0] out_ctrl2;
   logic [PW-1:0] out_payload2;
   logic [AW-1:0] out_dst2;
   logic [3:0]    bubble_cnt2;

   id_exe_stage_hs dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_payload(in_payload), .in_dst(in_dst), .in_link(in_link),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_payload(out_payload), .out_dst(out_dst), .out_link(out_link), .bubble_cnt(bubble_cnt)
   );

   id_exe_stage_hs #(.LINK_REG(30), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .in_ctrl(in_ctrl), .in_payload(in_payload), .in_dst(in_dst), .in_link(in_link),
      .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2),
      .out_payload(out_payload2), .out_dst(out_dst2), .out_link(out_link2), .bubble_cnt(bubble_cnt2)
   );

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [PW-1:0] payload;
      logic [AW-1:0] dst;
      logic          link;
   } ent_t;

   // Reference model: the stage is a 2-deep FIFO whose ready is "fewer than 2 held", seen one edge late.
   ent_t q[$];
   bit   mrdy = 1'b1;
   int   bcnt = 0;
   int   bcnt2 = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      bit v;
      v = (q.size() > 0);
      check("out_valid", out_valid, v);
      check("out_valid2", out_valid2, v);
      check("in_ready", in_ready, mrdy);
      check("in_ready2", in_ready2, mrdy);
      check("bubble_cnt", bubble_cnt, bcnt);
      check("bubble_cnt2", bubble_cnt2, bcnt2);
      if (v) begin
         check("out_ctrl", out_ctrl, q[0].ctrl);
         check("out_link", out_link, q[0].link);
         check("out_payload", out_payload, q[0].payload);
         check("out_dst", out_dst, q[0].link ? 5'd31 : q[0].dst);
         check("out_dst2", out_dst2, q[0].link ? 5'd30 : q[0].dst);
      end else begin
         check("out_ctrl_bubble", out_ctrl, 0);
         check("out_link_bubble", out_link, 0);
         check("out_ctrl2_bubble", out_ctrl2, 0);
      end
   endtask

   task automatic model_edge();
      bit   push;
      bit   pop;
      ent_t e;
      push = in_valid && mrdy;
      pop  = (q.size() > 0) && out_ready;
      if (out_ready && q.size() == 0) begin
         if (bcnt < 65535) bcnt++;
         if (bcnt2 < 15) bcnt2++;
      end
      if (flush) begin
         q.delete();
         mrdy = 1'b1;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            e.ctrl = in_ctrl; e.payload = in_payload; e.dst = in_dst; e.link = in_link;
            q.push_back(e);
         end
         mrdy = (q.size() < 2);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      q.delete();
      mrdy = 1'b1; bcnt = 0; bcnt2 = 0;
      @(negedge clk);
      compare_all();
      check("rst_payload", out_payload, 0);
      check("rst_dst", out_dst, 0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic set_in(input bit v, input logic [CW-1:0] c, input logic [AW-1:0] d, input bit l);
      in_valid = v; in_ctrl = c; in_dst = d; in_link = l;
      in_payload = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      #2 reset = 1'b0;
      do_reset();

      // 1: single entry, one-cycle latency, bubble afterwards
      out_ready = 1'b1;
      set_in(1, 12'h0A5, 5'd7, 0);
      cycle();
      check("t1_valid", out_valid, 1);
      check("t1_ctrl", out_ctrl, 12'h0A5);
      check("t1_dst", out_dst, 5'd7);
      in_valid = 1'b0;
      cycle();
      check("t1_valid_after", out_valid, 0);
      check("t1_ctrl_after", out_ctrl, 0);

      // 2: backpressure into skid, C held, then drained in order
      out_ready = 1'b0;
      set_in(1, 12'h111, 5'd1, 0); cycle();
      set_in(1, 12'h222, 5'd2, 0); cycle();
      check("t2_rdy_low", in_ready, 0);
      set_in(1, 12'h333, 5'd3, 0); cycle(); cycle();
      check("t2_hold_A", out_ctrl, 12'h111);
      out_ready = 1'b1;
      cycle();
      check("t2_B", out_ctrl, 12'h222);
      check("t2_rdy_back", in_ready, 1);
      cycle();
      in_valid = 1'b0;
      check("t2_C", out_ctrl, 12'h333);
      cycle();
      check("t2_drained", out_valid, 0);

      // 3: link override
      set_in(1, 12'h0F0, 5'd4, 1); cycle();
      check("t3_dst", out_dst, 5'd31);
      check("t3_link", out_link, 1);
      check("t3_dst_lr30", out_dst2, 5'd30);
      in_valid = 1'b0; cycle();

      // 4: flush in SKID with a concurrent offer D
      out_ready = 1'b0;
      set_in(1, 12'h0E1, 5'd9, 0); cycle();
      set_in(1, 12'h0E2, 5'd10, 0); cycle();
      check("t4_skid", in_ready, 0);
      set_in(1, 12'h444, 5'd11, 0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      check("t4_valid", out_valid, 0);
      check("t4_ctrl", out_ctrl, 0);
      check("t4_rdy", in_ready, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t4_no_D", out_valid, 0);
      end

      // 5: bubble counter saturation, cleared only by reset
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 70000; i++) cycle();
      check("t5_sat", bubble_cnt, 16'hFFFF);
      check("t5_sat_w4", bubble_cnt2, 4'hF);
      cycle(); cycle();
      check("t5_stick", bubble_cnt, 16'hFFFF);
      do_reset();
      check("t5_cleared", bubble_cnt, 0);

      // 6: streaming at full rate
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         set_in(1, CW'($urandom), AW'($urandom), $urandom_range(0, 1));
         cycle();
         check("t6_rdy", in_ready, 1);
         check("t6_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      cycle();

      // Random traffic with occasional flush; upstream holds while stalled
      for (int i = 0; i < 3000; i++) begin
         if (!(in_valid && !mrdy))
            set_in($urandom_range(0, 2) != 0, CW'($urandom), AW'($urandom), $urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 31) == 0);
         cycle();
      end
      flush = 1'b0;

      // Asynchronous reset in the middle of a stream
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_in(1, CW'($urandom), AW'($urandom), 0);
         cycle();
      end
      #2 reset = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_ctrl", out_ctrl, 0);
      check("arst_rdy", in_ready, 1);
      check("arst_bubble", bubble_cnt, 0);
      check("arst_dst", out_dst, 0);
      q.delete(); mrdy = 1'b1; bcnt = 0; bcnt2 = 0;
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
